// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Handshaked ALU; single-cycle logic/arith/shift ops, iterative
//            shift-add multiply, result and ZNCV flags held until consumed.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sig_alu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Output,
    output logic             flag_zero,
    output logic             flag_negative,
    output logic             flag_carry,
    output logic             flag_overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_sll = 4'd3;
    localparam logic [3:0] c_op_slr = 4'd4;
    localparam logic [3:0] c_op_or  = 4'd5;
    localparam logic [3:0] c_op_sra = 4'd6;
    localparam logic [3:0] c_op_mul = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2*WIDTH-1:0]     r_a_shift;
    logic [WIDTH-1:0]       r_b_shift;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]       r_count;

    logic [WIDTH-1:0]       w_res;
    logic                   w_carry;
    logic                   w_ovf;
    logic                   w_shift_big;
    logic [SHAMT_W-1:0]     w_shamt;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic                   w_mul_last;
    logic                   w_accept;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = in_valid && in_ready;

    assign w_shift_big = (B > WIDTH'(WIDTH - 1));
    assign w_shamt     = B[SHAMT_W-1:0];
    assign w_acc_next  = r_b_shift[0] ? (r_acc + r_a_shift) : r_acc;
    assign w_mul_last  = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (sig_alu_op == c_op_mul) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Single-cycle result; reserved ops (and MUL, handled elsewhere) give 0.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (sig_alu_op)
            c_op_add: begin
                {w_carry, w_res} = {1'b0, A} + {1'b0, B};
                w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            end
            c_op_sub: begin
                w_res   = A - B;
                w_carry = (A < B);
                w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            end
            c_op_and: w_res = A & B;
            c_op_or:  w_res = A | B;
            c_op_sll: w_res = w_shift_big ? '0 : (A << w_shamt);
            c_op_slr: w_res = w_shift_big ? '0 : (A >> w_shamt);
            c_op_sra: w_res = w_shift_big ? {WIDTH{A[WIDTH-1]}}
                                          : $unsigned($signed(A) >>> w_shamt);
            default:  w_res = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            Output        <= '0;
            flag_zero     <= 1'b0;
            flag_negative <= 1'b0;
            flag_carry    <= 1'b0;
            flag_overflow <= 1'b0;
            r_a_shift     <= '0;
            r_b_shift     <= '0;
            r_acc         <= '0;
            r_count       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (sig_alu_op == c_op_mul) begin
                            r_a_shift <= {{WIDTH{1'b0}}, A};
                            r_b_shift <= B;
                            r_acc     <= '0;
                            r_count   <= '0;
                        end else begin
                            Output        <= w_res;
                            flag_zero     <= (w_res == '0);
                            flag_negative <= w_res[WIDTH-1];
                            flag_carry    <= w_carry;
                            flag_overflow <= w_ovf;
                        end
                    end
                end
                S_MUL: begin
                    r_acc     <= w_acc_next;
                    r_a_shift <= r_a_shift << 1;
                    r_b_shift <= r_b_shift >> 1;
                    r_count   <= r_count + CNT_W'(1);
                    // The last partial product is folded in directly from the adder.
                    if (w_mul_last) begin
                        Output        <= w_acc_next[WIDTH-1:0];
                        flag_zero     <= (w_acc_next[WIDTH-1:0] == '0);
                        flag_negative <= w_acc_next[WIDTH-1];
                        flag_carry    <= |w_acc_next[2*WIDTH-1:WIDTH];
                        flag_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
